secuenciador_and_or: RTL and testbench
======================================

// Module: secuenciador_and_or
// PURPOSE
//  Self-test sequencer for the registered 3-input AND-OR datapath (out = iA[2] | (iA[1] & iA[0])).
//  On a start pulse it sweeps every input combination into the datapath.
//  For each combination it waits out the pipeline latency and captures the result into a truth table.
//  It compares the table against an expected mask, then reports the table, the mismatch count and pass/fail.
//  Sits beside the AND-OR datapath, driving its input bus and reading its output.
// PARAMETERS
//  N_IN     3      datapath input width; table depth = 2**N_IN
//  LATENCY  2      clock edges from an oA change until iSalidaDut is valid; legal range 1..15
//  EXPECTED 8'hF8  golden truth table (width 2**N_IN); bit k = expected output for input k
// PORTS
//  iClk        in   1          clock; all state changes on rising edge
//  iRst_n      in   1          asynchronous, active-low reset
//  iStart      in   1          sweep request; sampled only in IDLE
//  iSalidaDut  in   1          datapath output (oSalida of the AND-OR block)
//  oA          out  N_IN       input vector driven to the datapath
//  oBusy       out  1          high from the edge accepting iStart until DONE is left
//  oDone       out  1          one-cycle pulse; results valid
//  oTabla      out  2**N_IN    captured truth table; bit k = output for input k
//  oErrores    out  N_IN+1     number of bits where oTabla != EXPECTED (0..2**N_IN)
//  oPass       out  1          1 when the last completed sweep had oErrores == 0
// BEHAVIOUR
//  Reset (async, iRst_n=0): state=IDLE. oA, oBusy, oDone, oTabla, oErrores, oPass, vector and wait counters all 0.
//   Takes effect immediately, with no clock edge required, including mid-sweep.
//  States: IDLE, SETTLE, CAPTURE, DONE. All outputs are registered.
//  IDLE: oBusy=0.
//   On an edge with iStart=1 -> SETTLE.
//   At that edge: oA<=0, vector k<=0, oTabla<=0, oErrores<=0, oPass<=0, wait counter<=0, oBusy<=1.
//  SETTLE: wait counter increments each edge.
//   After LATENCY cycles in SETTLE -> CAPTURE (wait counter cleared).
//  CAPTURE (one cycle), at the edge leaving it:
//   - oTabla[k] <= iSalidaDut.
//   - If iSalidaDut != EXPECTED[k], oErrores <= oErrores+1. No overflow is possible at width N_IN+1.
//   - If k == 2**N_IN-1 -> DONE; oA holds its value.
//   - Otherwise k<=k+1, oA<=k+1, -> SETTLE.
//  Timing: each vector is held on oA for exactly LATENCY+1 cycles.
//   iSalidaDut is sampled on the (LATENCY+1)th edge after the edge that loaded oA.
//  DONE (one cycle): oDone=1, oBusy=1, oPass<=(oErrores==0) at the entry edge.
//   Next edge -> IDLE, with oDone<=0 and oBusy<=0.
//  Defaults: the last capture is on edge 24 after the iStart-sampling edge; oDone is high during the following cycle.
//  oTabla, oErrores and oPass hold their values after DONE until the next accepted iStart clears them.
//  iStart is ignored in SETTLE, CAPTURE and DONE: no restart, no queuing.
//   iStart held high continuously -> a new sweep is accepted on the first edge spent in IDLE.
//  oA wraps nowhere: the sweep stops at 2**N_IN-1; the vector counter never rolls over to 0 mid-sweep.
//  Simultaneous reset and any other event: reset wins.
// TESTING
//  1 Reset: hold iRst_n=0 with random inputs
//    -> all outputs 0; release reset; iStart=0 for 10 cycles -> oBusy stays 0, oA stays 0.
//  2 Golden sweep: model the 2-stage AND-OR datapath; pulse iStart for one cycle
//    -> oA steps 0..7, each held 3 cycles; oDone pulses once, 25 cycles after the iStart edge;
//       oTabla=8'hF8, oErrores=0, oPass=1, oBusy low one cycle later.
//  3 Faulty datapath, output stuck at 0 -> oTabla=8'h00, oErrores=5, oPass=0.
//    Output stuck at 1 -> oTabla=8'hFF, oErrores=3, oPass=0.
//  4 Re-pulse iStart at cycles 5 and 20 of a sweep -> single oDone, oA sequence undisturbed.
//    Hold iStart high -> back-to-back sweeps, with exactly one IDLE cycle between DONE and the next SETTLE.
//  5 Drop iRst_n asynchronously (between clock edges) while oA=4
//    -> outputs clear before the next edge; a subsequent iStart gives a full clean sweep from oA=0 with oPass=1.
//  6 LATENCY=1 with a 1-stage datapath model -> each vector held 2 cycles, oDone 17 cycles after the iStart edge, oTabla=8'hF8.

Source files
------------

// File: rtl/secuenciador_and_or.sv
// Self-test sequencer for a registered 3-input AND-OR datapath.
// On a start request it walks every input vector onto the datapath bus.
// For each vector it waits out the pipeline latency and then captures the
// datapath output into a truth table. At the end it counts the bits that
// differ from the golden table and reports pass/fail.
module secuenciador_and_or #(
    parameter int                        N_IN     = 3,
    parameter int                        LATENCY  = 2,
    parameter logic [(1 << N_IN) - 1:0]  EXPECTED = 8'hF8
) (
    input  logic                      iClk,
    input  logic                      iRst_n,
    input  logic                      iStart,
    input  logic                      iSalidaDut,
    output logic [N_IN-1:0]           oA,
    output logic                      oBusy,
    output logic                      oDone,
    output logic [(1 << N_IN) - 1:0]  oTabla,
    output logic [N_IN:0]             oErrores,
    output logic                      oPass
);

    localparam int DEPTH  = 1 << N_IN;
    localparam int WAIT_W = 4;

    // Last vector of the sweep; the vector counter stops here and never wraps.
    localparam logic [N_IN-1:0]   LAST_VEC = N_IN'(DEPTH - 1);
    // The settle phase lasts LATENCY cycles, so it ends when the counter
    // has reached LATENCY-1 (LATENCY is limited to 1..15).
    localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [N_IN-1:0]    vec_q, vec_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [DEPTH-1:0]   tabla_q, tabla_d;
    logic [N_IN:0]      err_q, err_d;
    logic               pass_q, pass_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Mismatch of the current sample against the golden bit for this vector.
    logic               bit_mismatch;

    assign bit_mismatch = (iSalidaDut != EXPECTED[vec_q]);

    // Next-state and next-output logic of the sweep controller.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        wait_d  = wait_q;
        tabla_d = tabla_q;
        err_d   = err_q;
        pass_d  = pass_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (iStart) begin
                    // A new sweep wipes the previous results.
                    state_d = ST_SETTLE;
                    vec_d   = '0;
                    wait_d  = '0;
                    tabla_d = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            ST_SETTLE: begin
                if (wait_q == WAIT_END) begin
                    wait_d  = '0;
                    state_d = ST_CAPTURE;
                end else begin
                    wait_d  = wait_q + WAIT_W'(1);
                end
            end

            ST_CAPTURE: begin
                tabla_d[vec_q] = iSalidaDut;
                if (bit_mismatch) begin
                    // At most DEPTH increments, which fits in N_IN+1 bits.
                    err_d = err_q + (N_IN + 1)'(1);
                end
                if (vec_q == LAST_VEC) begin
                    // The verdict uses the count including this last sample.
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    vec_d   = vec_q + N_IN'(1);
                    state_d = ST_SETTLE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register; every output comes straight from a flop.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            wait_q  <= '0;
            tabla_q <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            wait_q  <= wait_d;
            tabla_q <= tabla_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // The vector counter doubles as the datapath input bus.
    assign oA       = vec_q;
    assign oBusy    = busy_q;
    assign oDone    = done_q;
    assign oTabla   = tabla_q;
    assign oErrores = err_q;
    assign oPass    = pass_q;

    // Results are only announced while the sweep is still flagged busy.
    a_done_busy: assert property (@(posedge iClk) disable iff (!iRst_n)
        done_q |-> busy_q);

    // The settle counter never runs past the configured latency.
    a_wait_range: assert property (@(posedge iClk) disable iff (!iRst_n)
        (state_q == ST_SETTLE) |-> (wait_q <= WAIT_END));

    // The done pulse is exactly one cycle wide.
    a_done_pulse: assert property (@(posedge iClk) disable iff (!iRst_n)
        done_q |=> !done_q);

endmodule

// File: tb/tb_secuenciador_and_or.sv
// Bench for secuenciador_and_or: two instances (LATENCY 2 and 1), each
// next to a behavioural AND-OR datapath with optional stuck-at faults.
// Accepted sweeps push the expected report into a queue; a monitor pops it
// on oDone and also checks oA/oBusy/oDone cycle by cycle.
module tb_secuenciador_and_or;

    localparam int          DEPTH  = 8;
    localparam logic [7:0]  GOLDEN = 8'hF8;

    typedef struct {
        logic [7:0] tabla;
        logic [3:0] errs;
        logic       pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start [2];
    logic [1:0] fault [2];   // 0 healthy, 1 stuck at 0, 2 stuck at 1
    int         checks = 0;
    int         fails  = 0;
    int         cyc    = 0;

    always #5 clk = ~clk;

    // Edge index counter: read at a posedge it gives that edge's index.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    // Expected report of a full sweep, straight from the boolean function.
    function automatic exp_t ref_sweep(input logic [1:0] f);
        exp_t r;
        r.tabla = '0;
        for (int k = 0; k < DEPTH; k++) begin
            int o;
            if (f == 2'd1)      o = 0;
            else if (f == 2'd2) o = 1;
            else                o = ((k / 4) % 2) | (((k / 2) % 2) & (k % 2));
            r.tabla[k] = (o != 0);
        end
        r.errs = 4'($countones(r.tabla ^ GOLDEN));
        r.pass = (r.errs == 0);
        return r;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : gen_dut
        localparam int LAT    = (gi == 0) ? 2 : 1;
        localparam int LAST_T = DEPTH * (LAT + 1);

        logic [2:0] a;
        logic       busy, done, pass;
        logic [7:0] tabla;
        logic [3:0] errs;
        logic       s1 = 1'b0, s2 = 1'b0;
        logic       dp_core, dp;

        // Registered AND-OR datapath, LAT stages deep.
        always @(posedge clk) begin
            s1 <= a[2] | (a[1] & a[0]);
            s2 <= s1;
        end
        assign dp_core = (LAT == 2) ? s2 : s1;
        assign dp = (fault[gi] == 2'd1) ? 1'b0 : (fault[gi] == 2'd2) ? 1'b1 : dp_core;

        secuenciador_and_or #(
            .N_IN(3), .LATENCY(LAT), .EXPECTED(8'hF8)
        ) dut (
            .iClk(clk), .iRst_n(rst_n), .iStart(start[gi]), .iSalidaDut(dp),
            .oA(a), .oBusy(busy), .oDone(done), .oTabla(tabla),
            .oErrores(errs), .oPass(pass)
        );

        exp_t sb[$];
        exp_t e;
        int   s_edge  = 0;
        int   next_ok = 0;
        bit   active  = 1'b0;
        int   t;

        // Acceptance model: a start is taken once the previous sweep has
        // finished its DONE cycle and spent one edge back in IDLE.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sb.delete();
                active  <= 1'b0;
                next_ok <= 0;
            end else if (start[gi] && cyc >= next_ok) begin
                sb.push_back(ref_sweep(fault[gi]));
                s_edge  <= cyc;
                active  <= 1'b1;
                next_ok <= cyc + LAST_T + 2;
            end
        end

        // Monitor, sampling mid-cycle.
        always @(negedge clk) begin
            if (rst_n) begin
                t = cyc - 1 - s_edge;
                if (active && t <= LAST_T) begin
                    chk($sformatf("u%0d.oA t=%0d", gi, t), a,
                        ((t / (LAT + 1)) > 7) ? 7 : (t / (LAT + 1)));
                    chk($sformatf("u%0d.oBusy t=%0d", gi, t), busy, 1);
                    chk($sformatf("u%0d.oDone t=%0d", gi, t), done, (t == LAST_T) ? 1 : 0);
                    if (done) begin
                        if (sb.size() == 0) begin
                            chk($sformatf("u%0d.unexpected_done", gi), 1, 0);
                        end else begin
                            e = sb.pop_front();
                            chk($sformatf("u%0d.oTabla", gi), tabla, e.tabla);
                            chk($sformatf("u%0d.oErrores", gi), errs, e.errs);
                            chk($sformatf("u%0d.oPass", gi), pass, e.pass);
                            $display("u%0d sweep done: tabla=%02h errores=%0d pass=%0d",
                                     gi, tabla, errs, pass);
                        end
                    end
                end else begin
                    chk($sformatf("u%0d.oDone_idle", gi), done, 0);
                    if (active && t == LAST_T + 1)
                        chk($sformatf("u%0d.oBusy_after_done", gi), busy, 0);
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, ".u0.oA"},       gen_dut[0].a,     0);
        chk({tag, ".u0.oBusy"},    gen_dut[0].busy,  0);
        chk({tag, ".u0.oDone"},    gen_dut[0].done,  0);
        chk({tag, ".u0.oTabla"},   gen_dut[0].tabla, 0);
        chk({tag, ".u0.oErrores"}, gen_dut[0].errs,  0);
        chk({tag, ".u0.oPass"},    gen_dut[0].pass,  0);
        chk({tag, ".u1.oA"},       gen_dut[1].a,     0);
        chk({tag, ".u1.oBusy"},    gen_dut[1].busy,  0);
        chk({tag, ".u1.oDone"},    gen_dut[1].done,  0);
        chk({tag, ".u1.oTabla"},   gen_dut[1].tabla, 0);
        chk({tag, ".u1.oErrores"}, gen_dut[1].errs,  0);
        chk({tag, ".u1.oPass"},    gen_dut[1].pass,  0);
    endtask

    task automatic pulse(input logic s0, input logic s1);
        @(negedge clk);
        start[0] = s0;
        start[1] = s1;
        @(negedge clk);
        start[0] = 1'b0;
        start[1] = 1'b0;
    endtask

    // Bounded wait until both sequencers are idle.
    task automatic wait_idle();
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while ((gen_dut[0].busy || gen_dut[1].busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 1, 0);
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        start[0] = 1'b0;
        start[1] = 1'b0;
        fault[0] = 2'd0;
        fault[1] = 2'd0;

        // Reset held with random inputs.
        repeat (4) begin
            @(negedge clk);
            start[0] = 1'($urandom);
            start[1] = 1'($urandom);
            fault[0] = 2'($urandom_range(0, 2));
            fault[1] = 2'($urandom_range(0, 2));
            #1 check_zero("reset");
        end
        start[0] = 1'b0;
        start[1] = 1'b0;
        fault[0] = 2'd0;
        fault[1] = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("quiet.u0.oBusy", gen_dut[0].busy, 0);
            chk("quiet.u0.oA",    gen_dut[0].a,    0);
            chk("quiet.u1.oBusy", gen_dut[1].busy, 0);
        end

        // Golden sweep on both latencies.
        pulse(1'b1, 1'b1);
        wait_idle();

        // Stuck-at faults.
        fault[0] = 2'd1;
        fault[1] = 2'd2;
        pulse(1'b1, 1'b1);
        wait_idle();
        fault[0] = 2'd2;
        fault[1] = 2'd1;
        pulse(1'b1, 1'b1);
        wait_idle();
        fault[0] = 2'd0;
        fault[1] = 2'd0;

        // Re-pulses during a sweep are ignored.
        pulse(1'b1, 1'b0);
        repeat (3) @(negedge clk);
        pulse(1'b1, 1'b1);
        repeat (13) @(negedge clk);
        pulse(1'b1, 1'b1);
        wait_idle();

        // Start held high: back-to-back sweeps.
        @(negedge clk);
        start[0] = 1'b1;
        start[1] = 1'b1;
        repeat (70) @(negedge clk);
        start[0] = 1'b0;
        start[1] = 1'b0;
        wait_idle();

        // Asynchronous reset mid-sweep, while oA = 4.
        pulse(1'b1, 1'b1);
        n = 0;
        while (gen_dut[0].a != 3'd4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_oA4", (n < 50) ? 1 : 0, 1);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        pulse(1'b1, 1'b1);
        wait_idle();
        chk("post_reset.u0.oPass", gen_dut[0].pass, 1);
        chk("post_reset.u0.oTabla", gen_dut[0].tabla, 8'hF8);

        // Randomized sweeps.
        repeat (8) begin
            fault[0] = 2'($urandom_range(0, 2));
            fault[1] = 2'($urandom_range(0, 2));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            pulse(1'b1, 1'($urandom));
            wait_idle();
        end

        repeat (3) @(negedge clk);
        chk("u0.scoreboard_drained", gen_dut[0].sb.size(), 0);
        chk("u1.scoreboard_drained", gen_dut[1].sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
